// File: rtl/param_interval_timer.sv
// Parametrised Avalon-MM interval timer with prescaler, timeout strobe
// and missed-timeout status; register map extends the 16-bit timer.
module param_interval_timer #(
  parameter int COUNT_WIDTH    = 32,
  parameter int PRESCALE_WIDTH = 8,
  parameter int RESET_PERIOD   = 63
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        timeout_pulse
);

  localparam int HW = COUNT_WIDTH - 16;
  localparam logic [COUNT_WIDTH-1:0] LP_RST =
    COUNT_WIDTH'(RESET_PERIOD);

  logic [COUNT_WIDTH-1:0]    r_counter;
  logic [COUNT_WIDTH-1:0]    r_period;
  logic [COUNT_WIDTH-1:0]    r_snap;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] r_pcnt;
  logic                      r_ito;
  logic                      r_cont;
  logic                      r_start;
  logic                      r_stop;
  logic                      r_to;
  logic                      r_run;
  logic                      r_missed;
  logic                      r_force;
  logic                      r_nz;
  logic                      r_pulse;
  logic [15:0]               r_readdata;

  logic        w_wr;
  logic        w_wr_st;
  logic        w_wr_ctl;
  logic        w_wr_reload;
  logic        w_wr_snap;
  logic        w_zero;
  logic        w_event;
  logic        w_tick;
  logic        w_hold;
  logic [15:0] w_rdmux;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_st     = w_wr & (address == 3'd0);
  assign w_wr_ctl    = w_wr & (address == 3'd1);
  assign w_wr_reload = w_wr & ((address == 3'd2) |
                               (address == 3'd3) |
                               (address == 3'd6));
  assign w_wr_snap   = w_wr & ((address == 3'd4) |
                               (address == 3'd5));

  assign w_zero  = (r_counter == '0);
  assign w_event = w_zero & r_nz;
  assign w_tick  = r_run & (r_pcnt == '0);
  // a one-shot timer parks at zero instead of reloading
  assign w_hold  = w_event & ~r_cont;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period   <= LP_RST;
      r_prescale <= '0;
      r_ito      <= 1'b0;
      r_cont     <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_snap     <= '0;
    end else if (w_wr) begin
      unique case (address)
        3'd1: begin
          r_ito   <= writedata[0];
          r_cont  <= writedata[1];
          r_start <= writedata[2];
          r_stop  <= writedata[3];
        end
        3'd2: r_period[15:0] <= writedata;
        3'd3: r_period[COUNT_WIDTH-1:16] <= writedata[HW-1:0];
        3'd4: r_snap <= r_counter;
        3'd5: r_snap <= r_counter;
        3'd6: r_prescale <= writedata[PRESCALE_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_counter <= LP_RST;
      r_pcnt    <= '0;
      r_force   <= 1'b0;
      r_nz      <= 1'b0;
    end else begin
      r_force <= w_wr_reload;
      r_nz    <= ~w_zero;
      if (r_force) begin
        r_counter <= r_period;
        r_pcnt    <= r_prescale;
      end else if (w_tick) begin
        r_pcnt <= r_prescale;
        if (!w_zero)
          r_counter <= r_counter - COUNT_WIDTH'(1);
        else if (!w_hold)
          r_counter <= r_period;
      end else if (r_run) begin
        r_pcnt <= r_pcnt - PRESCALE_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run    <= 1'b0;
      r_to     <= 1'b0;
      r_missed <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_pulse <= w_event;
      if (w_wr_ctl && writedata[2])
        r_run <= 1'b1;
      else if ((w_wr_ctl && writedata[3]) || r_force || w_hold)
        r_run <= 1'b0;
      // an event beats a simultaneous status clear
      if (w_event) begin
        r_to     <= 1'b1;
        r_missed <= w_wr_st ? 1'b0 : (r_missed | r_to);
      end else if (w_wr_st) begin
        r_to     <= 1'b0;
        r_missed <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdmux = '0;
    unique case (address)
      3'd0: w_rdmux = {13'd0, r_missed, r_run, r_to};
      3'd1: w_rdmux = {12'd0, r_stop, r_start, r_cont, r_ito};
      3'd2: w_rdmux = r_period[15:0];
      3'd3: w_rdmux = 16'(r_period[COUNT_WIDTH-1:16]);
      3'd4: w_rdmux = r_snap[15:0];
      3'd5: w_rdmux = 16'(r_snap[COUNT_WIDTH-1:16]);
      3'd6: w_rdmux = 16'(r_prescale);
      default: w_rdmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_readdata <= '0;
    else
      r_readdata <= w_rdmux;
  end

  assign readdata      = r_readdata;
  assign irq           = r_to & r_ito;
  assign timeout_pulse = r_pulse;

endmodule

// File: tb/tb_param_interval_timer.sv
// Scoreboard bench for param_interval_timer: read and pulse
// expectations are queued by the driver and popped by a monitor.
module tb_param_interval_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic        irq;
  logic        timeout_pulse;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int s;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;

  logic [15:0] rq_exp[$];
  string       rq_name[$];
  int          pq[$];

  param_interval_timer #(
    .COUNT_WIDTH(20),
    .PRESCALE_WIDTH(8),
    .RESET_PERIOD(63)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_vld <= rd_req;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_vld) begin
      if (rq_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_queue: read with no expectation");
      end else begin
        check(rq_name.pop_front(), 32'(readdata), 32'(rq_exp.pop_front()));
      end
    end
    if (reset_n && timeout_pulse) begin
      if (pq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pulse_unexpected: pulse at cycle %0d expected none",
                 cyc);
      end else begin
        check("pulse_cycle", 32'(cyc), 32'(pq.pop_front()));
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp,
                    input string name);
    address = a;
    rq_exp.push_back(exp);
    rq_name.push_back(name);
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_readdata", 32'(readdata), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_pulse", 32'(timeout_pulse), 32'h0);
    reset_n = 1'b1;

    // 1: reset map, continuous 64-cycle period
    rd(3'd2, 16'd63, "t1_period_l");
    rd(3'd3, 16'd0, "t1_period_h");
    rd(3'd0, 16'd0, "t1_status");
    rd(3'd1, 16'd0, "t1_control");
    rd(3'd6, 16'd0, "t1_prescale");
    rd(3'd7, 16'd0, "t1_addr7");
    wr(3'd6, 16'd0);
    wr(3'd1, 16'h6);
    s = cyc;
    pq.push_back(s + 64);
    pq.push_back(s + 128);
    pq.push_back(s + 192);
    wait_cyc(s + 200);
    rd(3'd0, 16'h7, "t1_status_run");
    check("t1_irq", 32'(irq), 32'h0);
    wr(3'd0, 16'h0);
    rd(3'd0, 16'h2, "t1_status_clr");

    // 2: one-shot, period 9, prescale 3
    wr(3'd2, 16'd9);
    wr(3'd3, 16'd0);
    wr(3'd6, 16'd3);
    wr(3'd1, 16'h5);
    s = cyc;
    pq.push_back(s + 37);
    wait_cyc(s + 60);
    rd(3'd0, 16'h1, "t2_status");
    check("t2_irq", 32'(irq), 32'h1);
    rd(3'd1, 16'h5, "t2_control");
    rd(3'd6, 16'd3, "t2_prescale");
    wr(3'd4, 16'h0);
    rd(3'd4, 16'h0, "t2_snap_l");
    rd(3'd5, 16'h0, "t2_snap_h");
    wait_cyc(s + 90);

    // 3 and 4: continuous period 4, missed flag, clear race
    wr(3'd0, 16'h0);
    wr(3'd2, 16'd4);
    wr(3'd6, 16'd0);
    wr(3'd1, 16'h7);
    s = cyc;
    pq.push_back(s + 5);
    pq.push_back(s + 10);
    pq.push_back(s + 15);
    pq.push_back(s + 20);
    wait_cyc(s + 12);
    rd(3'd0, 16'h7, "t3_status_missed");
    check("t3_irq_set", 32'(irq), 32'h1);
    wr(3'd0, 16'h0);
    check("t3_irq_clr", 32'(irq), 32'h0);
    rd(3'd0, 16'h2, "t3_status_clr");
    wait_cyc(s + 19);
    wr(3'd0, 16'h0);
    check("t4_irq_race", 32'(irq), 32'h1);
    rd(3'd0, 16'h3, "t4_status_race");
    wr(3'd1, 16'h8);
    rd(3'd1, 16'h8, "t4_control_stop");
    rd(3'd0, 16'h1, "t4_status_stop");
    check("t4_irq_ito0", 32'(irq), 32'h0);

    // 5: snapshot and force reload
    wr(3'd0, 16'h0);
    wr(3'd2, 16'd1000);
    wr(3'd1, 16'h6);
    s = cyc;
    wait_cyc(s + 100);
    wr(3'd4, 16'h0);
    rd(3'd4, 16'd900, "t5_snap_l");
    rd(3'd5, 16'd0, "t5_snap_h");
    rd(3'd0, 16'h2, "t5_status_run");
    wr(3'd2, 16'd500);
    idle();
    wr(3'd5, 16'h0);
    rd(3'd4, 16'd500, "t5_snap_reload");
    rd(3'd0, 16'h0, "t5_status_reload");
    wr(3'd3, 16'd2);
    idle();
    wr(3'd4, 16'h0);
    rd(3'd4, 16'h01F4, "t5_snap_l_hi");
    rd(3'd5, 16'h0002, "t5_snap_h_hi");

    // 6: period_h width and reset mid-count
    wr(3'd3, 16'hFFFF);
    rd(3'd3, 16'h000F, "t6_period_h");
    wr(3'd1, 16'h6);
    idle();
    idle();
    check("t6_readdata_live", 32'(readdata), 32'h6);
    reset_n = 1'b0;
    #1;
    check("t6_rst_readdata", 32'(readdata), 32'h0);
    check("t6_rst_irq", 32'(irq), 32'h0);
    check("t6_rst_pulse", 32'(timeout_pulse), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd(3'd2, 16'd63, "t6_period_l");
    rd(3'd3, 16'd0, "t6_period_h_rst");
    rd(3'd0, 16'd0, "t6_status");
    rd(3'd1, 16'd0, "t6_control");
    rd(3'd6, 16'd0, "t6_prescale");
    wr(3'd4, 16'h0);
    rd(3'd4, 16'd63, "t6_counter_l");
    rd(3'd5, 16'd0, "t6_counter_h");

    repeat (5) idle();
    check("pulse_queue_left", 32'(pq.size()), 32'h0);
    check("rd_queue_left", 32'(rq_exp.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
